// File: rtl/ram_bist_ctrl.sv
// BIST initiator for the single-port ram: writes a seeded address pattern, reads it back and compares,
// then repeats with the inverted pattern and reports pass/fail, mismatch count and first failing address.
module ram_bist_ctrl #(
    parameter int                 ADDR_W = 8,
    parameter int                 DATA_W = 8,
    parameter int                 DEPTH  = 256,
    parameter logic [DATA_W-1:0]  SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [7:0]        CNT_MAX   = 8'hFF;

    // Expected cell content: address XOR seed, inverted in the second pass.
    function automatic logic [DATA_W-1:0] pattern_f(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] v;
        v = DATA_W'(a) ^ SEED;
        return inv ? ~v : v;
    endfunction

    state_t            state_r;
    logic              pass_idx_r;
    logic              cmp_vld_r;
    logic [DATA_W-1:0] exp_d_r;
    logic [ADDR_W-1:0] addr_d_r;

    logic              mismatch_s;
    logic [7:0]        fail_count_nxt_s;
    logic [ADDR_W-1:0] first_fail_nxt_s;
    logic [ADDR_W-1:0] addr_inc_s;

    // Compare the delayed expectation against read data and form the next error bookkeeping.
    always_comb begin
        mismatch_s       = 1'b0;
        fail_count_nxt_s = fail_count;
        first_fail_nxt_s = first_fail_addr;
        addr_inc_s       = ram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cmp_vld_r && (data_out != exp_d_r)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
        if (mismatch_s && (fail_count != CNT_MAX)) begin
            fail_count_nxt_s = fail_count + 8'd1;
        end else begin
            fail_count_nxt_s = fail_count;
        end
        if (mismatch_s && (fail_count == 8'd0)) begin
            first_fail_nxt_s = addr_d_r;
        end else begin
            first_fail_nxt_s = first_fail_addr;
        end
    end

    // Test sequencer with registered RAM-side and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            pass_idx_r      <= 1'b0;
            cmp_vld_r       <= 1'b0;
            exp_d_r         <= DATA_ZERO;
            addr_d_r        <= ADDR_ZERO;
            wr              <= 1'b0;
            ram_addr        <= ADDR_ZERO;
            data_in         <= DATA_ZERO;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= 8'd0;
            first_fail_addr <= ADDR_ZERO;
        end else begin
            // Read data returns one cycle after the address, so the expectation trails by one.
            cmp_vld_r       <= (state_r == ST_READ);
            exp_d_r         <= pattern_f(ram_addr, pass_idx_r);
            addr_d_r        <= ram_addr;
            fail_count      <= fail_count_nxt_s;
            first_fail_addr <= first_fail_nxt_s;
            done            <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wr   <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state_r         <= ST_WRITE;
                        pass_idx_r      <= 1'b0;
                        wr              <= 1'b1;
                        busy            <= 1'b1;
                        ram_addr        <= ADDR_ZERO;
                        data_in         <= pattern_f(ADDR_ZERO, 1'b0);
                        fail_count      <= 8'd0;
                        first_fail_addr <= ADDR_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (ram_addr == LAST_ADDR) begin
                        state_r  <= ST_READ;
                        wr       <= 1'b0;
                        ram_addr <= ADDR_ZERO;
                        data_in  <= DATA_ZERO;
                    end else begin
                        ram_addr <= addr_inc_s;
                        data_in  <= pattern_f(addr_inc_s, pass_idx_r);
                    end
                end
                ST_READ: begin
                    if (ram_addr == LAST_ADDR) begin
                        state_r  <= ST_FLUSH;
                        ram_addr <= ADDR_ZERO;
                    end else begin
                        ram_addr <= addr_inc_s;
                    end
                end
                ST_FLUSH: begin
                    if (!pass_idx_r) begin
                        state_r    <= ST_WRITE;
                        pass_idx_r <= 1'b1;
                        wr         <= 1'b1;
                        ram_addr   <= ADDR_ZERO;
                        data_in    <= pattern_f(ADDR_ZERO, 1'b1);
                    end else begin
                        // The last read is compared in this cycle, so judge on the updated count.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (fail_count_nxt_s == 8'd0);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    wr      <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (DEPTH 16 and 256) on faultable RAM models, checked every
// cycle against a timeline/result model derived from the pattern rules.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_a [2];
    logic       rst_a   [2];
    logic       wr_a    [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       pass_a  [2];
    logic [7:0] addr_a  [2];
    logic [7:0] din_a   [2];
    logic [7:0] dout_a  [2];
    logic [7:0] fc_a    [2];
    logic [7:0] ffa_a   [2];

    int fmode [2];
    int faddr [2];
    int fbit  [2];

    int total = 0;
    int bad   = 0;

    // Fault overlay on read data: 1 bit stuck-0 at one addr, 2 bit stuck-1 everywhere,
    // 3 bus tied to zero, 4 bit stuck-1 at one addr.
    function automatic logic [7:0] flt(input int i, input logic [7:0] a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        case (fmode[i])
            1: if (int'(a) == faddr[i]) r[fbit[i]] = 1'b0;
            2: r[fbit[i]] = 1'b1;
            3: r = 8'h00;
            4: if (int'(a) == faddr[i]) r[fbit[i]] = 1'b1;
            default: r = v;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [256];
        logic [7:0] rdq = 8'h00;
        logic [7:0] rda = 8'h00;
        always @(posedge clk) begin
            if (wr_a[g]) mem[addr_a[g]] <= din_a[g];
            else begin
                rdq <= mem[addr_a[g]];
                rda <= addr_a[g];
            end
        end
        assign dout_a[g] = flt(g, rda, rdq);

        ram_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(g == 0 ? 16 : 256), .SEED(8'hA5)) u_dut (
            .clk(clk), .rst(rst_a[g]), .start(start_a[g]),
            .wr(wr_a[g]), .ram_addr(addr_a[g]), .data_in(din_a[g]), .data_out(dout_a[g]),
            .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]),
            .fail_count(fc_a[g]), .first_fail_addr(ffa_a[g])
        );
    end

    task automatic chk(input int i, input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL inst%0d %s: got %0h want %0h (cycle %0d)", i, nm, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] expv(input int a, input int p);
        logic [7:0] v;
        v = 8'(a) ^ 8'hA5;
        return (p != 0) ? ~v : v;
    endfunction

    // Reference model state
    bit         act [2];
    int         t0  [2];
    int         dep [2] = '{16, 256};
    logic       cur_pass [2];
    logic [7:0] cur_cnt  [2];
    logic [7:0] cur_ffa  [2];
    logic       res_pass [2];
    logic [7:0] res_cnt  [2];
    logic [7:0] res_ffa  [2];
    int snap_a, snap_b, snap_done;

    task automatic calc(input int i);
        int cnt, ffa;
        logic [7:0] e;
        cnt = 0; ffa = 0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < dep[i]; a++) begin
                e = expv(a, p);
                if (flt(i, 8'(a), e) != e) begin
                    if (cnt == 0) ffa = a;
                    if (cnt < 255) cnt++;
                end
            end
        res_cnt[i]  = 8'(cnt);
        res_ffa[i]  = 8'(ffa);
        res_pass[i] = (cnt == 0);
    endtask

    // Per-cycle comparison against the model timeline.
    always @(negedge clk) begin
        int k, d, a, p, ph;
        for (int i = 0; i < 2; i++) begin
            if (rst_a[i]) begin
                act[i] = 0; cur_pass[i] = 0; cur_cnt[i] = 0; cur_ffa[i] = 0;
            end else if (act[i]) begin
                k = cyc - t0[i]; d = dep[i]; a = 0; p = 0;
                if (k <= d)              begin ph = 0; a = k - 1; end
                else if (k <= 2*d)       begin ph = 1; a = k - d - 1; end
                else if (k == 2*d + 1)   ph = 2;
                else if (k <= 3*d + 1)   begin ph = 0; a = k - 2*d - 2; p = 1; end
                else if (k <= 4*d + 1)   begin ph = 1; a = k - 3*d - 2; p = 1; end
                else if (k == 4*d + 2)   ph = 2;
                else                     ph = 3;
                chk(i, "wr", wr_a[i], ph == 0);
                chk(i, "busy", busy_a[i], ph != 3);
                chk(i, "done", done_a[i], ph == 3);
                chk(i, "pass", pass_a[i], (ph == 3) ? res_pass[i] : cur_pass[i]);
                if (ph == 0) begin
                    chk(i, "wr_addr", addr_a[i], a);
                    chk(i, "wr_data", din_a[i], expv(a, p));
                end
                if (ph == 1) begin
                    chk(i, "rd_addr", addr_a[i], a);
                    chk(i, "rd_data_in", din_a[i], 0);
                end
                if (i == 0) begin
                    if (k == 4) snap_a = din_a[0];
                    if (k == 2*d + 5) snap_b = din_a[0];
                    if (done_a[0]) snap_done = k;
                end
                if (ph == 3) begin
                    chk(i, "fail_count", fc_a[i], res_cnt[i]);
                    chk(i, "first_fail_addr", ffa_a[i], res_ffa[i]);
                    act[i] = 0;
                    cur_pass[i] = res_pass[i]; cur_cnt[i] = res_cnt[i]; cur_ffa[i] = res_ffa[i];
                end
            end else begin
                chk(i, "idle_wr", wr_a[i], 0);
                chk(i, "idle_busy", busy_a[i], 0);
                chk(i, "idle_done", done_a[i], 0);
                chk(i, "idle_pass", pass_a[i], cur_pass[i]);
                chk(i, "idle_fail_count", fc_a[i], cur_cnt[i]);
                chk(i, "idle_first_fail", ffa_a[i], cur_ffa[i]);
                if (start_a[i]) begin
                    act[i] = 1; t0[i] = cyc; calc(i);
                    if (i == 0) snap_done = -1;
                end
            end
        end
    end

    // One test on instance i; start at k=0, optional extra starts and a reset at given offsets.
    task automatic run(input int i, input int m, input int fa, input int fb,
                       input int rst_at, input int xs1, input int xs2);
        int t, k;
        bit fin;
        fmode[i] = m; faddr[i] = fa; fbit[i] = fb;
        @(posedge clk); #1;
        t = cyc; fin = 0;
        for (int n = 0; n < 6000 && !fin; n++) begin
            k = cyc - t;
            if (n > 1 && !act[i]) fin = 1;
            else begin
                start_a[i] = (k == 0) || (k == xs1) || (k == xs2);
                rst_a[i]   = (k == rst_at);
                @(posedge clk); #1;
            end
        end
        start_a[i] = 0; rst_a[i] = 0;
        if (!fin) begin
            total++; bad++;
            $display("FAIL inst%0d timeout: got no completion want done", i);
        end
    endtask

    task automatic lit(input int i, input int cnt, input int ffa, input int ps);
        @(negedge clk);
        chk(i, "lit_fail_count", fc_a[i], cnt);
        chk(i, "lit_first_fail", ffa_a[i], ffa);
        chk(i, "lit_pass", pass_a[i], ps);
    endtask

    initial begin
        int i, d, rs, x1, x2;
        start_a = '{1'b0, 1'b0};
        rst_a   = '{1'b1, 1'b1};
        fmode = '{0, 0}; faddr = '{0, 0}; fbit = '{0, 0};
        repeat (2) @(posedge clk);
        #1 rst_a = '{1'b0, 1'b0};
        repeat (10) @(posedge clk);

        // Good RAM, DEPTH=16
        run(0, 0, 0, 0, -1, -1, -1);
        lit(0, 0, 0, 1);
        chk(0, "lit_wdata_a3_p0", snap_a, 8'hA6);
        chk(0, "lit_wdata_a3_p1", snap_b, 8'h59);
        chk(0, "lit_done_offset", snap_done, 67);

        // Stuck-at-0 bit0 at address 5
        run(0, 1, 5, 0, -1, -1, -1);
        lit(0, 1, 5, 0);

        // bit7 stuck at 1 everywhere
        run(0, 2, 0, 7, -1, -1, -1);
        lit(0, 16, 0, 0);

        // Saturation, DEPTH=256, bus tied low
        run(1, 3, 0, 0, -1, -1, -1);
        lit(1, 255, 0, 0);

        // Reset mid-test then a clean rerun
        run(0, 0, 0, 0, 10, -1, -1);
        lit(0, 0, 0, 0);
        run(0, 0, 0, 0, -1, -1, -1);
        lit(0, 0, 0, 1);

        // Ignored start pulses
        run(0, 0, 0, 0, -1, 5, 40);
        chk(0, "lit_done_offset_xs", snap_done, 67);
        lit(0, 0, 0, 1);

        // Randomized tests
        for (int n = 0; n < 14; n++) begin
            i  = ($urandom_range(0, 5) == 0) ? 1 : 0;
            d  = dep[i];
            rs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4*d + 2)) : -1;
            x1 = int'($urandom_range(1, 4*d + 3));
            x2 = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 4*d + 3));
            run(i, int'($urandom_range(0, 4)), int'($urandom_range(0, d - 1)),
                int'($urandom_range(0, 7)), rs, x1, x2);
            repeat (int'($urandom_range(1, 4))) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
